// File: rtl/prach_pkg.sv
// prach_pkg: shared widths, saturation limits and coefficient/rounding helpers
package prach_pkg;
  localparam int DATA_WIDTH = 18;
  localparam int COEF_WIDTH = 18;
  localparam int COEF_FRAC = 16;
  localparam int PROD_WIDTH = DATA_WIDTH + COEF_WIDTH + 1;
  typedef logic signed [DATA_WIDTH-1:0] sample_t;
  typedef logic signed [COEF_WIDTH-1:0] coef_t;
  typedef logic signed [PROD_WIDTH-1:0] prod_t;
  typedef struct packed {
    logic dv;
    logic sync;
    logic dv_ahead;
    logic sync_ahead;
  } flags_t;
  localparam sample_t SAT_MAX = 18'sh1ffff;
  localparam sample_t SAT_MIN = 18'sh20000;
  function automatic coef_t coef(int k, int n, bit sn);
    real a;
    real v;
    a = 6.283185307179586 * k / n;
    v = 65536.0 * (sn ? $sin(a) : $cos(a));
    return coef_t'(v >= 0.0 ? $rtoi(v + 0.5) : -$rtoi(0.5 - v));
  endfunction
  function automatic sample_t sat_rnd(prod_t p);
    prod_t t;
    t = (p + prod_t'(1 << (COEF_FRAC - 1))) >>> COEF_FRAC;
    return t > prod_t'(SAT_MAX) ? SAT_MAX : t < prod_t'(SAT_MIN) ? SAT_MIN : sample_t'(t);
  endfunction
endpackage

// File: rtl/prach_ditfft2_twiddle_if.sv
// prach_ditfft2_twiddle_if: complex sample stream with valid, sync and early-warning flags
interface prach_ditfft2_twiddle_if;
  import prach_pkg::*;
  sample_t dr;
  sample_t di;
  logic dv;
  logic sync;
  logic dv_ahead;
  logic sync_ahead;
  modport master(output dr, di, dv, sync, dv_ahead, sync_ahead);
  modport slave(input dr, di, dv, sync, dv_ahead, sync_ahead);
endinterface

// File: rtl/prach_twiddle_rom.sv
// prach_twiddle_rom: registered (cos, sin) table for k = 0..N/2-1, built at elaboration
module prach_twiddle_rom
  import prach_pkg::*;
#(
  parameter int N = 6,
  localparam int AW = $clog2(N / 2)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] i_addr,
  output coef_t         o_c,
  output coef_t         o_s
);
  coef_t w_c [N/2];
  coef_t w_s [N/2];
  coef_t r_c, r_s;
  for (genvar k = 0; k < N / 2; k++) begin : g_tab
    localparam coef_t C = coef(k, N, 1'b0);
    localparam coef_t S = coef(k, N, 1'b1);
    assign w_c[k] = C;
    assign w_s[k] = S;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_c <= '0;
      r_s <= '0;
    end else begin
      r_c <= w_c[i_addr];
      r_s <= w_s[i_addr];
    end
  end
  assign o_c = r_c;
  assign o_s = r_s;
endmodule

// File: rtl/prach_ditfft2_twiddle.sv
// prach_ditfft2_twiddle: multiplies the upper half of each N-sample frame by W^k, 4-cycle latency
module prach_ditfft2_twiddle
  import prach_pkg::*;
#(
  parameter int NUM_FFT_LENGTH = 6
) (
  input logic clk,
  input logic rst_n,
  prach_ditfft2_twiddle_if.slave  i_din,
  prach_ditfft2_twiddle_if.master o_dout
);
  localparam int N = NUM_FFT_LENGTH;
  localparam int H = N / 2;
  localparam int CW = $clog2(N);
  localparam int AW = $clog2(H);
  logic [CW-1:0] r_cnt, w_idx;
  logic w_mul;
  logic [AW-1:0] w_addr;
  coef_t w_c, w_s;
  sample_t r_xr1, r_xi1, r_xr2, r_xi2, r_yr3, r_yi3, r_yr4, r_yi4;
  logic r_mul1, r_mul2;
  prod_t r_pr2, r_pi2;
  flags_t w_fin;
  flags_t [3:0] r_flg;
  always_comb begin
    w_idx = i_din.sync ? '0 : r_cnt;
    w_mul = w_idx >= CW'(H);
    w_addr = w_mul ? AW'(w_idx - CW'(H)) : '0;
    w_fin = '{dv: i_din.dv, sync: i_din.sync, dv_ahead: i_din.dv_ahead, sync_ahead: i_din.sync_ahead};
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_cnt <= '0;
    else if (i_din.dv) r_cnt <= (w_idx == CW'(N - 1)) ? '0 : w_idx + CW'(1);
  end
  prach_twiddle_rom #(.N(N)) u_rom (
    .clk(clk),
    .rst_n(rst_n),
    .i_addr(w_addr),
    .o_c(w_c),
    .o_s(w_s)
  );
  // stage 1 aligns data with the ROM read; stage 2 multiplies; stage 3 rounds/saturates
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_xr1 <= '0;
      r_xi1 <= '0;
      r_mul1 <= 1'b0;
      r_xr2 <= '0;
      r_xi2 <= '0;
      r_mul2 <= 1'b0;
      r_pr2 <= '0;
      r_pi2 <= '0;
      r_yr3 <= '0;
      r_yi3 <= '0;
      r_yr4 <= '0;
      r_yi4 <= '0;
      r_flg <= '0;
    end else begin
      r_xr1 <= i_din.dr;
      r_xi1 <= i_din.di;
      r_mul1 <= w_mul;
      r_xr2 <= r_xr1;
      r_xi2 <= r_xi1;
      r_mul2 <= r_mul1;
      r_pr2 <= prod_t'(r_xr1) * prod_t'(w_c) + prod_t'(r_xi1) * prod_t'(w_s);
      r_pi2 <= prod_t'(r_xi1) * prod_t'(w_c) - prod_t'(r_xr1) * prod_t'(w_s);
      r_yr3 <= r_mul2 ? sat_rnd(r_pr2) : r_xr2;
      r_yi3 <= r_mul2 ? sat_rnd(r_pi2) : r_xi2;
      r_yr4 <= r_yr3;
      r_yi4 <= r_yi3;
      r_flg <= {r_flg[2:0], w_fin};
    end
  end
  assign o_dout.dr = r_yr4;
  assign o_dout.di = r_yi4;
  assign o_dout.dv = r_flg[3].dv;
  assign o_dout.sync = r_flg[3].sync;
  assign o_dout.dv_ahead = r_flg[3].dv_ahead;
  assign o_dout.sync_ahead = r_flg[3].sync_ahead;
endmodule

// File: tb/tb_prach_ditfft2_twiddle.sv
// tb_prach_ditfft2_twiddle: directed vectors for N=8 with hand-computed twiddled outputs
module tb_prach_ditfft2_twiddle;
  logic clk;
  logic rst_n;
  int n_chk;
  int n_fail;
  int n;
  int e_f [128];
  int e_r [128];
  int e_i [128];
  prach_ditfft2_twiddle_if u_in ();
  prach_ditfft2_twiddle_if u_out ();
  prach_ditfft2_twiddle #(.NUM_FFT_LENGTH(8)) u_dut (
    .clk(clk),
    .rst_n(rst_n),
    .i_din(u_in),
    .o_dout(u_out)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  task automatic chk_zero(input string tag);
    check({tag, "_flags"}, int'({u_out.dv, u_out.sync, u_out.dv_ahead, u_out.sync_ahead}), 0);
    check({tag, "_dr"}, int'(u_out.dr), 0);
    check({tag, "_di"}, int'(u_out.di), 0);
  endtask
  // f = {dv, sync, dv_ahead, sync_ahead}; output of vector j is checked 4 edges after it is sampled
  task automatic drv(input logic [3:0] f, input int xr, input int xi, input int er, input int ei);
    e_f[n] = int'(f);
    e_r[n] = er;
    e_i[n] = ei;
    {u_in.dv, u_in.sync, u_in.dv_ahead, u_in.sync_ahead} = f;
    u_in.dr = 18'(xr);
    u_in.di = 18'(xi);
    @(posedge clk);
    #1;
    if (n >= 3) begin
      check($sformatf("flags[%0d]", n - 3), int'({u_out.dv, u_out.sync, u_out.dv_ahead, u_out.sync_ahead}), e_f[n-3]);
      if (e_f[n-3] >= 8) begin
        check($sformatf("dr[%0d]", n - 3), int'(u_out.dr), e_r[n-3]);
        check($sformatf("di[%0d]", n - 3), int'(u_out.di), e_i[n-3]);
      end
    end
    n++;
  endtask
  task automatic gap();
    drv(4'b0000, 77, -77, 0, 0);
    drv(4'b0001, -55, 55, 0, 0);
  endtask
  initial begin
    n_chk = 0;
    n_fail = 0;
    n = 0;
    rst_n = 1'b0;
    {u_in.dv, u_in.sync, u_in.dv_ahead, u_in.sync_ahead} = 4'b1111;
    u_in.dr = 18'sd1234;
    u_in.di = -18'sd99;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    drv(4'b1110, 100, -200, 100, -200);
    drv(4'b1010, 5, 7, 5, 7);
    drv(4'b1001, -3, 4, -3, 4);
    drv(4'b1000, 131071, -131072, 131071, -131072);
    drv(4'b1011, 1000, 0, 1000, 0);
    drv(4'b1000, 1000, 0, 707, -707);
    drv(4'b1010, 1000, 0, 0, -1000);
    drv(4'b1000, 1000, 0, -707, -707);
    drv(4'b1000, 7, 8, 7, 8);
    drv(4'b1000, -9, 10, -9, 10);
    drv(4'b1000, 0, 0, 0, 0);
    drv(4'b1000, 1, 1, 1, 1);
    drv(4'b1000, 1000, -3, 1000, -3);
    drv(4'b1000, -131072, -131072, -131072, 0);
    drv(4'b1000, 0, 1000, 1000, 0);
    drv(4'b1000, 1000, 0, -707, -707);
    for (int i = 0; i < 5; i++) drv(4'b1000, i * 3, -i, i * 3, -i);
    drv(4'b1000, 131071, 131071, 131071, 0);
    drv(4'b1000, 1000, 0, 0, -1000);
    drv(4'b1000, -1000, 0, 707, 707);
    for (int i = 0; i < 5; i++) begin
      drv(4'b1000, 20 + i, -i, 20 + i, -i);
      gap();
    end
    drv(4'b1100, 1000, 0, 1000, 0);
    gap();
    for (int i = 1; i < 5; i++) begin
      drv(4'b1010, 30 + i, i, 30 + i, i);
      gap();
    end
    drv(4'b1000, 1000, 0, 707, -707);
    gap();
    drv(4'b0000, 0, 0, 0, 0);
    drv(4'b1100, 1000, 0, 1000, 0);
    for (int i = 1; i < 5; i++) drv(4'b1011, 1000, 0, 1000, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero("rst_async");
    @(posedge clk);
    #1;
    chk_zero("rst_hold");
    {u_in.dv, u_in.sync, u_in.dv_ahead, u_in.sync_ahead} = 4'b0000;
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    drv(4'b1000, 1000, 0, 1000, 0);
    for (int i = 1; i < 5; i++) drv(4'b1000, 1000, 0, 1000, 0);
    drv(4'b1000, 1000, 0, 707, -707);
    drv(4'b1000, 1000, 0, 0, -1000);
    repeat (4) drv(4'b0000, 0, 0, 0, 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
